// File: rtl/rdp_systolic_pkg.sv
// Shared definitions for the systolic lane buffer: handshake helper and default widths.
package rdp_systolic_pkg;

  localparam int unsigned DataWDef = 32;
  localparam int unsigned LenWDef  = 16;
  localparam int unsigned DepthDef = 4;

  // A token moves on a channel when both sides agree at the clock edge.
  function automatic logic xfer(input logic req, input logic ack);
    return req & ack;
  endfunction

endpackage

// File: rtl/rdp_systolic_fifo.sv
// Single-lane req/ack FIFO with occupancy output; ack depends on registered level only.
module rdp_systolic_fifo
  import rdp_systolic_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned DEPTH  = DepthDef,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned LvlW  = PtrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_req_i,
  output logic              in_ack_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_req_o,
  input  logic              out_ack_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [LvlW-1:0]   level_o
);

  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              push, pop;

  always_comb begin
    in_ack_o   = (level_q < LvlFull);
    out_req_o  = (level_q != '0);
    out_data_o = mem_q[rd_ptr_q];
    level_o    = level_q;

    push = xfer(in_req_i, in_ack_o);
    pop  = xfer(out_req_o, out_ack_i);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
      end
    end
  end

endmodule

// File: rtl/rdp_systolic_lane_buf_2.sv
// Two independent elastic lanes behind the 5->2 join, plus a lane-1 pass counter.
module rdp_systolic_lane_buf_2
  import rdp_systolic_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned DEPTH  = DepthDef,
  parameter int unsigned LEN_W  = LenWDef
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     t_k1_req,
  output logic                     t_k1_ack,
  input  logic [DATA_W-1:0]        t_k1_data,
  input  logic                     t_k2_req,
  output logic                     t_k2_ack,
  input  logic [DATA_W-1:0]        t_k2_data,
  output logic                     i_k1_req,
  input  logic                     i_k1_ack,
  output logic [DATA_W-1:0]        i_k1_data,
  output logic                     i_k2_req,
  input  logic                     i_k2_ack,
  output logic [DATA_W-1:0]        i_k2_data,
  input  logic [LEN_W-1:0]         cfg_len,
  output logic                     pass_done,
  output logic [$clog2(DEPTH):0]   lvl_k1,
  output logic [$clog2(DEPTH):0]   lvl_k2
);

  rdp_systolic_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo_k1 (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .in_req_i   (t_k1_req),
    .in_ack_o   (t_k1_ack),
    .in_data_i  (t_k1_data),
    .out_req_o  (i_k1_req),
    .out_ack_i  (i_k1_ack),
    .out_data_o (i_k1_data),
    .level_o    (lvl_k1)
  );

  rdp_systolic_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo_k2 (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .in_req_i   (t_k2_req),
    .in_ack_o   (t_k2_ack),
    .in_data_i  (t_k2_data),
    .out_req_o  (i_k2_req),
    .out_ack_i  (i_k2_ack),
    .out_data_o (i_k2_data),
    .level_o    (lvl_k2)
  );

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cfg_eff, len_eff;
  logic             pass_done_q, pass_done_d;
  logic             k1_out_xfer;

  always_comb begin
    k1_out_xfer = xfer(i_k1_req, i_k1_ack);
    cfg_eff     = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    // At a pass boundary the live config applies; mid-pass the latched length holds.
    len_eff     = (cnt_q == '0) ? cfg_eff : len_q;
    len_d       = len_eff;

    cnt_d       = cnt_q;
    pass_done_d = 1'b0;
    if (k1_out_xfer) begin
      if (cnt_q == len_eff - LEN_W'(1)) begin
        cnt_d       = '0;
        pass_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      len_q       <= LEN_W'(1);
      pass_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      pass_done_q <= pass_done_d;
    end
  end

  assign pass_done = pass_done_q;

endmodule

// File: tb/tb_rdp_systolic_lane_buf_2.sv
// Self-checking bench: hand-derived vector table, pass-length sequences and random traffic
// against a queue-based reference model.
module tb_rdp_systolic_lane_buf_2;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          t_k1_req = 1'b0, t_k2_req = 1'b0;
  logic          t_k1_ack, t_k2_ack;
  logic [DW-1:0] t_k1_data = '0, t_k2_data = '0;
  logic          i_k1_req, i_k2_req;
  logic          i_k1_ack = 1'b0, i_k2_ack = 1'b0;
  logic [DW-1:0] i_k1_data, i_k2_data;
  logic [LW-1:0] cfg_len = 16'd1;
  logic          pass_done;
  logic [2:0]    lvl_k1, lvl_k2;

  always #5 clk = ~clk;

  rdp_systolic_lane_buf_2 #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .LEN_W  (LW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .t_k1_req  (t_k1_req),
    .t_k1_ack  (t_k1_ack),
    .t_k1_data (t_k1_data),
    .t_k2_req  (t_k2_req),
    .t_k2_ack  (t_k2_ack),
    .t_k2_data (t_k2_data),
    .i_k1_req  (i_k1_req),
    .i_k1_ack  (i_k1_ack),
    .i_k1_data (i_k1_data),
    .i_k2_req  (i_k2_req),
    .i_k2_ack  (i_k2_ack),
    .i_k2_data (i_k2_data),
    .cfg_len   (cfg_len),
    .pass_done (pass_done),
    .lvl_k1    (lvl_k1),
    .lvl_k2    (lvl_k2)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per-lane token queues and a pass tracker (position within pass).
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  int            pos_m;
  int            cur_len_m;
  logic          pd_m;

  // Samples taken at the most recent negedge.
  logic          s_a1, s_a2, s_r1, s_r2, s_pd;
  logic [DW-1:0] s_d1;
  logic [2:0]    s_l1, s_l2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    pos_m     = 0;
    cur_len_m = 1;
    pd_m      = 1'b0;
  endtask

  // Called at posedge+1: checks outputs at the negedge, then advances the model over the edge.
  task automatic step();
    bit push1, pop1, push2, pop2, pd_n;
    int len_now;
    @(negedge clk);
    s_a1 = t_k1_ack; s_a2 = t_k2_ack; s_r1 = i_k1_req; s_r2 = i_k2_req;
    s_d1 = i_k1_data; s_l1 = lvl_k1; s_l2 = lvl_k2; s_pd = pass_done;
    chk("t_k1_ack", 32'(t_k1_ack), 32'(q1.size() < DEPTH));
    chk("t_k2_ack", 32'(t_k2_ack), 32'(q2.size() < DEPTH));
    chk("i_k1_req", 32'(i_k1_req), 32'(q1.size() != 0));
    chk("i_k2_req", 32'(i_k2_req), 32'(q2.size() != 0));
    chk("lvl_k1", 32'(lvl_k1), 32'(q1.size()));
    chk("lvl_k2", 32'(lvl_k2), 32'(q2.size()));
    chk("pass_done", 32'(pass_done), 32'(pd_m));
    if (q1.size() != 0) chk("i_k1_data", i_k1_data, q1[0]);
    if (q2.size() != 0) chk("i_k2_data", i_k2_data, q2[0]);

    push1 = t_k1_req && (q1.size() < DEPTH);
    push2 = t_k2_req && (q2.size() < DEPTH);
    pop1  = (q1.size() != 0) && i_k1_ack;
    pop2  = (q2.size() != 0) && i_k2_ack;
    // A new pass picks up its length from the config seen while no pass is in progress.
    if (pos_m == 0) cur_len_m = (int'(cfg_len) == 0) ? 1 : int'(cfg_len);
    len_now = cur_len_m;
    pd_n = 1'b0;
    if (pop1) begin
      pos_m++;
      if (pos_m == len_now) begin
        pos_m = 0;
        pd_n  = 1'b1;
      end
    end

    @(posedge clk);
    if (pop1)  void'(q1.pop_front());
    if (pop2)  void'(q2.pop_front());
    if (push1) q1.push_back(t_k1_data);
    if (push2) q2.push_back(t_k2_data);
    pd_m = pd_n;
    #1;
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_t_k1_ack", 32'(t_k1_ack), 32'd1);
    chk("rst_t_k2_ack", 32'(t_k2_ack), 32'd1);
    chk("rst_i_k1_req", 32'(i_k1_req), 32'd0);
    chk("rst_i_k2_req", 32'(i_k2_req), 32'd0);
    chk("rst_i_k1_data", i_k1_data, 32'd0);
    chk("rst_i_k2_data", i_k2_data, 32'd0);
    chk("rst_lvl_k1", 32'(lvl_k1), 32'd0);
    chk("rst_lvl_k2", 32'(lvl_k2), 32'd0);
    chk("rst_pass_done", 32'(pass_done), 32'd0);
    t_k1_req = 1'b0; t_k2_req = 1'b0; i_k1_ack = 1'b0; i_k2_ack = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          t1r; logic [DW-1:0] t1d; logic i1a;
    logic          t2r; logic [DW-1:0] t2d; logic i2a;
    int            l1;  int l2; logic a1; logic r1; logic [DW-1:0] d1; logic pd;
  } vec_t;

  localparam logic [DW-1:0] A1 = 32'hA1, A2 = 32'hA2, A3 = 32'hA3, A4 = 32'hA4;
  localparam logic [DW-1:0] A5 = 32'hA5, A6 = 32'hA6, A7 = 32'hA7, B1 = 32'hB1;

  int exp_pulses[$];

  task automatic run_pass(input int n, input int cfg0, input int cfg1, input int chg_after,
                          input string name);
    int xfers, pushed;
    int got[$];
    do_reset();
    cfg_len = LW'(cfg0);
    xfers = 0; pushed = 0;
    for (int c = 0; c < n + 4; c++) begin
      t_k1_req  = (pushed < n);
      t_k1_data = DW'(pushed);
      i_k1_ack  = 1'b1;
      step();
      if (s_pd) got.push_back(xfers);
      if (s_r1 && i_k1_ack) xfers++;
      if (s_a1 && t_k1_req) pushed++;
      if (xfers >= chg_after) cfg_len = LW'(cfg1);
    end
    t_k1_req = 1'b0;
    chk({name, "_xfers"}, 32'(xfers), 32'(n));
    chk({name, "_pulse_count"}, 32'(got.size()), 32'(exp_pulses.size()));
    for (int i = 0; i < exp_pulses.size() && i < got.size(); i++) begin
      chk({name, "_pulse_at"}, 32'(got[i]), 32'(exp_pulses[i]));
    end
  endtask

  initial begin
    vec_t vt[15];
    logic          p1, p2;
    logic [DW-1:0] exp_d;

    model_reset();
    #12;
    do_reset();

    // Fill lane 1 to full with lane 2 independent, then drain with push+pop at level 2 and 3.
    vt[0]  = '{1, A1, 0, 0, 0,  0, 0, 0, 1, 0, 0,  0};
    vt[1]  = '{1, A2, 0, 0, 0,  0, 1, 0, 1, 1, A1, 0};
    vt[2]  = '{1, A3, 0, 0, 0,  0, 2, 0, 1, 1, A1, 0};
    vt[3]  = '{1, A4, 0, 0, 0,  0, 3, 0, 1, 1, A1, 0};
    vt[4]  = '{1, A5, 0, 1, B1, 0, 4, 0, 0, 1, A1, 0};
    vt[5]  = '{1, A5, 1, 0, 0,  0, 4, 1, 0, 1, A1, 0};
    vt[6]  = '{1, A5, 1, 0, 0,  0, 3, 1, 1, 1, A2, 1};
    vt[7]  = '{0, 0,  1, 0, 0,  0, 3, 1, 1, 1, A3, 1};
    vt[8]  = '{0, 0,  0, 0, 0,  0, 2, 1, 1, 1, A4, 1};
    vt[9]  = '{0, 0,  0, 0, 0,  0, 2, 1, 1, 1, A4, 0};
    vt[10] = '{1, A6, 1, 0, 0,  1, 2, 1, 1, 1, A4, 0};
    vt[11] = '{1, A7, 1, 0, 0,  1, 2, 0, 1, 1, A5, 1};
    vt[12] = '{0, 0,  1, 0, 0,  1, 2, 0, 1, 1, A6, 1};
    vt[13] = '{0, 0,  1, 0, 0,  1, 1, 0, 1, 1, A7, 1};
    vt[14] = '{0, 0,  0, 0, 0,  0, 0, 0, 1, 0, 0,  1};
    cfg_len = 16'd1;
    for (int i = 0; i < 15; i++) begin
      t_k1_req = vt[i].t1r; t_k1_data = vt[i].t1d; i_k1_ack = vt[i].i1a;
      t_k2_req = vt[i].t2r; t_k2_data = vt[i].t2d; i_k2_ack = vt[i].i2a;
      step();
      chk($sformatf("tbl%0d_lvl_k1", i), 32'(s_l1), 32'(vt[i].l1));
      chk($sformatf("tbl%0d_lvl_k2", i), 32'(s_l2), 32'(vt[i].l2));
      chk($sformatf("tbl%0d_t_k1_ack", i), 32'(s_a1), 32'(vt[i].a1));
      chk($sformatf("tbl%0d_i_k1_req", i), 32'(s_r1), 32'(vt[i].r1));
      chk($sformatf("tbl%0d_pass_done", i), 32'(s_pd), 32'(vt[i].pd));
      if (vt[i].r1) chk($sformatf("tbl%0d_i_k1_data", i), s_d1, vt[i].d1);
    end

    // Streaming with both sinks ready: one-cycle latency, in-order, level never above 1.
    do_reset();
    i_k1_ack = 1'b1; i_k2_ack = 1'b1;
    for (int i = 0; i < 17; i++) begin
      t_k1_req  = (i < 16);
      t_k2_req  = (i < 16);
      t_k1_data = DW'(32'h10 + i);
      t_k2_data = DW'(32'h110 + i);
      step();
      chk("stream_req", 32'(s_r1), 32'(i != 0));
      if (i != 0) chk("stream_data", s_d1, DW'(32'h10 + i - 1));
      chk("stream_lvl_le1", 32'(s_l1 <= 3'd1 && s_l2 <= 3'd1), 32'd1);
    end
    t_k1_req = 1'b0; t_k2_req = 1'b0;

    // Pass lengths: fixed 3, zero meaning 1, and a mid-pass config change.
    exp_pulses = '{3, 6};
    run_pass(7, 3, 3, 1, "len3");
    exp_pulses = '{1, 2, 3, 4};
    run_pass(4, 0, 0, 1, "len0");
    exp_pulses = '{3, 8};
    run_pass(8, 3, 5, 1, "len3to5");

    // Random traffic against the model, with resets landing mid-operation.
    do_reset();
    p1 = 1'b0; p2 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (c == 500 || c == 1000) begin
        do_reset();
        p1 = 1'b0; p2 = 1'b0;
      end
      if (!p1) begin
        t_k1_req  = ($urandom_range(0, 2) != 0);
        t_k1_data = $urandom;
      end
      if (!p2) begin
        t_k2_req  = ($urandom_range(0, 2) != 0);
        t_k2_data = $urandom;
      end
      i_k1_ack = ($urandom_range(0, 3) != 0) && (c % 200 < 150);
      i_k2_ack = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 9) == 0) cfg_len = LW'($urandom_range(0, 5));
      step();
      p1 = t_k1_req && !s_a1;
      p2 = t_k2_req && !s_a2;
    end
    exp_d = '0;
    t_k1_req = 1'b0; t_k2_req = 1'b0;
    i_k1_ack = 1'b1; i_k2_ack = 1'b1;
    for (int c = 0; c < 8; c++) step();
    chk("drain_lvl_k1", 32'(lvl_k1), exp_d);
    chk("drain_lvl_k2", 32'(lvl_k2), exp_d);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
